// File: rtl/load_store_unit.sv
// load_store_unit: single-access load/store unit between the core decoder and
// a word-wide data-memory bus. Accepts one access in IDLE, holds the bus
// request in BUSY until mem_ready_i (or a timeout abort), and returns
// aligned, sign/zero-extended load data.
// Optional build macro: LSU_MISALIGN_CHECK_EN (reject misaligned H/W accesses).
module load_store_unit #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        core_req_i,
   input  logic        core_we_i,
   input  logic [2:0]  core_size_i,
   input  logic [31:0] core_addr_i,
   input  logic [31:0] core_wd_i,
   output logic [31:0] core_rd_o,
   output logic        core_stall_req_o,
   output logic        lsu_fault_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wd_o,
   input  logic [31:0] mem_rd_i,
   input  logic        mem_ready_i
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   state_t           state;
   state_t           state_next;
   logic [2:0]       size_q;
   logic [1:0]       off_q;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      rd_q;
   logic             legal;
   logic             misalign;
   logic             accept;
   logic             reject;
   logic             timeout_hit;
   logic             done;

   // Stores allow B/H/W only; loads additionally allow BU/HU.
   function automatic logic size_legal(input logic we, input logic [2:0] size);
      if (we) return (size == 3'd0) || (size == 3'd1) || (size == 3'd2);
      return (size == 3'd0) || (size == 3'd1) || (size == 3'd2) ||
             (size == 3'd4) || (size == 3'd5);
   endfunction

   // Loads always read the full word; stores enable only the addressed lanes.
   function automatic logic [3:0] lane_be(input logic we, input logic [2:0] size,
                                          input logic [1:0] off);
      if (!we) return 4'b1111;
      case (size[1:0])
         2'd0:    return 4'b0001 << off;
         2'd1:    return off[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   // Replicate store data across lanes so the byte enables pick the target.
   function automatic logic [31:0] lane_wd(input logic [2:0] size, input logic [31:0] wd);
      case (size[1:0])
         2'd0:    return {4{wd[7:0]}};
         2'd1:    return {2{wd[15:0]}};
         default: return wd;
      endcase
   endfunction

   // Pick the addressed byte/half of the bus word and extend it.
   function automatic logic [31:0] extend_load(input logic [2:0] size, input logic [1:0] off,
                                               input logic [31:0] word);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      case (off)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = off[1] ? word[31:16] : word[15:0];
      case (size)
         3'd0:    return {{24{b[7]}}, b};
         3'd1:    return {{16{h[15]}}, h};
         3'd4:    return {24'd0, b};
         3'd5:    return {16'd0, h};
         default: return word;
      endcase
   endfunction

   assign legal = size_legal(core_we_i, core_size_i);

`ifdef LSU_MISALIGN_CHECK_EN
   assign misalign = ((core_size_i[1:0] == 2'd1) && core_addr_i[0]) ||
                     ((core_size_i[1:0] == 2'd2) && (core_addr_i[1:0] != 2'd0));
`else
   assign misalign = 1'b0;
`endif

   assign accept      = (state == IDLE) && core_req_i && legal && !misalign;
   assign reject      = (state == IDLE) && core_req_i && (!legal || misalign);
   assign timeout_hit = (TIMEOUT > 0) && (state == BUSY) && (cnt == CNT_MAX);
   assign done        = (state == BUSY) && mem_ready_i && !timeout_hit;

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic: one access in flight, abort wins over a late ready.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = BUSY;
         BUSY:    if (done || timeout_hit) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output logic: stall, fault pulse, bus request and returned load data.
   always_comb begin
      mem_req_o        = (state == BUSY) && !timeout_hit;
      core_stall_req_o = 1'b0;
      lsu_fault_o      = 1'b0;
      core_rd_o        = rd_q;
      if (!rst_i) begin
         if (state == IDLE) core_stall_req_o = accept;
         else               core_stall_req_o = !mem_ready_i && !timeout_hit;
         lsu_fault_o = timeout_hit || ((state == IDLE) && core_req_i && legal && misalign);
      end
      if (done && !mem_we_o)      core_rd_o = extend_load(size_q, off_q, mem_rd_i);
      if (timeout_hit || reject)  core_rd_o = 32'd0;
   end

   // Latched bus fields, wait counter and held load result.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mem_we_o   <= 1'b0;
         mem_be_o   <= 4'd0;
         mem_addr_o <= 32'd0;
         mem_wd_o   <= 32'd0;
         size_q     <= 3'd0;
         off_q      <= 2'd0;
         cnt        <= '0;
         rd_q       <= 32'd0;
      end else begin
         if (accept) begin
            mem_we_o   <= core_we_i;
            mem_be_o   <= lane_be(core_we_i, core_size_i, core_addr_i[1:0]);
            mem_addr_o <= {core_addr_i[31:2], 2'b00};
            mem_wd_o   <= lane_wd(core_size_i, core_wd_i);
            size_q     <= core_size_i;
            off_q      <= core_addr_i[1:0];
            cnt        <= '0;
         end else if ((TIMEOUT > 0) && (state == BUSY) && !mem_ready_i && !timeout_hit) begin
            cnt <= cnt + CNT_W'(1);
         end
         if (done && !mem_we_o) rd_q <= extend_load(size_q, off_q, mem_rd_i);
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors with a scoreboard. Stimulus tasks push
// the expected completion/fault record; a negedge monitor pops and compares
// whenever the DUT completes a bus access or pulses lsu_fault_o.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        core_req = 1'b0;
   logic        core_we = 1'b0;
   logic [2:0]  core_size = 3'd0;
   logic [31:0] core_addr = 32'd0;
   logic [31:0] core_wd = 32'd0;
   logic [31:0] core_rd;
   logic        stall;
   logic        fault;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd = 32'd0;
   logic        mem_ready = 1'b0;

   typedef struct {
      bit          is_fault;
      bit          we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rd;
   } exp_t;

   exp_t        q[$];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] last_rd = 32'd0;

   load_store_unit #(.TIMEOUT(4)) dut (
      .clk_i(clk), .rst_i(rst),
      .core_req_i(core_req), .core_we_i(core_we), .core_size_i(core_size),
      .core_addr_i(core_addr), .core_wd_i(core_wd), .core_rd_o(core_rd),
      .core_stall_req_o(stall), .lsu_fault_o(fault),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
      .mem_addr_o(mem_addr), .mem_wd_o(mem_wd),
      .mem_rd_i(mem_rd), .mem_ready_i(mem_ready)
   );

   always #5 clk = ~clk;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Monitor: every completion or fault pulse must match the oldest expectation.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst && (fault || (mem_req && mem_ready))) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: fault=%b req=%b ready=%b with empty queue",
                     fault, mem_req, mem_ready);
         end else begin
            e = q.pop_front();
            check1("event_is_fault", fault, e.is_fault);
            check1("event_stall_low", stall, 1'b0);
            check32("event_core_rd", core_rd, e.rd);
            if (e.is_fault) begin
               check1("fault_req_low", mem_req, 1'b0);
            end else begin
               check1("done_we", mem_we, e.we);
               check32("done_be", {28'd0, mem_be}, {28'd0, e.be});
               check32("done_addr", mem_addr, e.addr);
               if (e.we) check32("done_wd", mem_wd, e.wd);
            end
         end
      end
   end

   // One legal access; caller is at posedge+1 with the DUT in IDLE.
   task automatic access(input bit we, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rdata, input int waits,
                         input logic [3:0] be, input logic [31:0] exp_wd,
                         input logic [31:0] exp_rd);
      exp_t e;
      core_req  = 1'b1;
      core_we   = we;
      core_size = size;
      core_addr = addr;
      core_wd   = wd;
      mem_ready = 1'b0;
      e.is_fault = 1'b0;
      e.we   = we;
      e.be   = be;
      e.addr = {addr[31:2], 2'b00};
      e.wd   = exp_wd;
      e.rd   = we ? last_rd : exp_rd;
      if (!we) last_rd = exp_rd;
      q.push_back(e);
      @(negedge clk);
      check1("req_cycle_stall", stall, 1'b1);
      check1("req_cycle_bus_idle", mem_req, 1'b0);
      @(posedge clk); #1;
      core_req  = 1'b0;
      core_addr = 32'h0BAD_0000;
      core_wd   = 32'h5555_5555;
      for (int k = 0; k < waits; k++) begin
         @(negedge clk);
         check1("wait_stall", stall, 1'b1);
         check1("wait_req", mem_req, 1'b1);
         check32("wait_addr", mem_addr, e.addr);
         check32("wait_be", {28'd0, mem_be}, {28'd0, be});
         @(posedge clk); #1;
      end
      mem_ready = 1'b1;
      mem_rd    = rdata;
      @(negedge clk);
      @(posedge clk); #1;
      mem_ready = 1'b0;
      mem_rd    = 32'h6666_6666;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         check1("idle_req", mem_req, 1'b0);
         check32("idle_rd_held", core_rd, last_rd);
         @(posedge clk); #1;
      end
   endtask

   task automatic illegal(input bit we, input logic [2:0] size);
      core_req  = 1'b1;
      core_we   = we;
      core_size = size;
      core_addr = 32'h0000_0700;
      @(negedge clk);
      check1("illegal_stall", stall, 1'b0);
      check1("illegal_fault", fault, 1'b0);
      check32("illegal_rd", core_rd, 32'd0);
      @(posedge clk); #1;
      core_req = 1'b0;
      @(negedge clk);
      check1("illegal_no_req", mem_req, 1'b0);
      @(posedge clk); #1;
   endtask

   task automatic timeout_load();
      exp_t e;
      core_req  = 1'b1;
      core_we   = 1'b0;
      core_size = 3'd2;
      core_addr = 32'h0000_0800;
      e.is_fault = 1'b1;
      e.we = 1'b0; e.be = 4'hF; e.addr = 32'h800; e.wd = 32'd0; e.rd = 32'd0;
      q.push_back(e);
      @(negedge clk);
      check1("to_req_stall", stall, 1'b1);
      @(posedge clk); #1;
      core_req = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check1("to_busy_req", mem_req, 1'b1);
         check1("to_busy_stall", stall, 1'b1);
         check1("to_busy_nofault", fault, 1'b0);
         @(posedge clk); #1;
      end
      @(negedge clk);
      check1("to_abort_req_low", mem_req, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      check1("to_pulse_over", fault, 1'b0);
      check1("to_idle_req", mem_req, 1'b0);
      check1("to_idle_stall", stall, 1'b0);
      @(posedge clk); #1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check1("rst_req", mem_req, 1'b0);
      check1("rst_we", mem_we, 1'b0);
      check1("rst_stall", stall, 1'b0);
      check1("rst_fault", fault, 1'b0);
      check32("rst_be", {28'd0, mem_be}, 32'd0);
      check32("rst_addr", mem_addr, 32'd0);
      check32("rst_wd", mem_wd, 32'd0);
      check32("rst_rd", core_rd, 32'd0);
      @(posedge clk); #1;

      // Back-to-back stores and loads, ready on the first BUSY cycle.
      access(1, 3'd0 + 3'd2, 32'h100, 32'hDEADBEEF, 32'd0, 0, 4'b1111, 32'hDEADBEEF, 32'd0);
      access(1, 3'd0, 32'h203, 32'h000000A5, 32'd0, 0, 4'b1000, 32'hA5A5A5A5, 32'd0);
      access(1, 3'd1, 32'h202, 32'h12345678, 32'd0, 0, 4'b1100, 32'h56785678, 32'd0);
      access(0, 3'd0, 32'h301, 32'd0, 32'h00008000, 0, 4'b1111, 32'd0, 32'hFFFFFF80);
      access(0, 3'd4, 32'h301, 32'd0, 32'h00008000, 0, 4'b1111, 32'd0, 32'h00000080);
      access(0, 3'd5, 32'h302, 32'd0, 32'hBEEF0000, 0, 4'b1111, 32'd0, 32'h0000BEEF);
      access(0, 3'd1, 32'h300, 32'd0, 32'h00008123, 0, 4'b1111, 32'd0, 32'hFFFF8123);
      idle(2);

      // Wait states: bus fields must stay put while stalled.
      access(0, 3'd2, 32'h400, 32'd0, 32'hCAFEF00D, 3, 4'b1111, 32'd0, 32'hCAFEF00D);
      access(1, 3'd0, 32'h001, 32'h00000077, 32'd0, 1, 4'b0010, 32'h77777777, 32'd0);
      idle(1);

      illegal(0, 3'd3);
      illegal(1, 3'd4);
      idle(1);

      timeout_load();
      idle(1);

`ifdef LSU_MISALIGN_CHECK_EN
      begin : misalign_reject
         exp_t e;
         core_req = 1'b1; core_we = 1'b0; core_size = 3'd2; core_addr = 32'h102;
         e.is_fault = 1'b1; e.we = 1'b0; e.be = 4'hF; e.addr = 32'h100;
         e.wd = 32'd0; e.rd = 32'd0;
         q.push_back(e);
         @(negedge clk);
         check1("mis_stall", stall, 1'b0);
         @(posedge clk); #1;
         core_req = 1'b0;
         @(negedge clk);
         check1("mis_no_req", mem_req, 1'b0);
         check1("mis_pulse_over", fault, 1'b0);
         @(posedge clk); #1;
      end
`else
      access(0, 3'd2, 32'h102, 32'd0, 32'h11223344, 0, 4'b1111, 32'd0, 32'h11223344);
      access(0, 3'd1, 32'h303, 32'd0, 32'h80010000, 0, 4'b1111, 32'd0, 32'hFFFF8001);
`endif

      // Reset in the second BUSY cycle abandons the access without a fault.
      core_req = 1'b1; core_we = 1'b1; core_size = 3'd2; core_addr = 32'h900;
      core_wd = 32'h01020304;
      @(negedge clk);
      check1("mr_req_stall", stall, 1'b1);
      @(posedge clk); #1;
      core_req = 1'b0;
      @(negedge clk);
      check1("mr_busy1_req", mem_req, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check1("mr_rst_stall_forced", stall, 1'b0);
      check1("mr_rst_nofault", fault, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      last_rd = 32'd0;
      @(negedge clk);
      check1("mr_after_req", mem_req, 1'b0);
      check1("mr_after_stall", stall, 1'b0);
      check32("mr_after_rd", core_rd, 32'd0);
      @(posedge clk); #1;

      access(0, 3'd2, 32'h500, 32'd0, 32'h00000005, 0, 4'b1111, 32'd0, 32'h00000005);
      idle(2);

      check32("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
